iddmm_ctrl: RTL

IDDMM_CTRL -- requirements
Module: iddmm_ctrl

---
 rtl/iddmm_pkg.sv | 19 +
 rtl/iddmm_ctrl_dly.sv | 31 +++
 rtl/iddmm_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/iddmm_pkg.sv
// Shared types and default parameters for the IDDMM multiplication controller.
package iddmm_pkg;

   // Controller states; binary encoded.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_FIN   = 2'd3
   } state_e;

   // Default operand geometry.
   localparam int unsigned DFLT_K = 128;
   localparam int unsigned DFLT_N = 32;

   // Datapath issue-to-result latency: multiplier, adder, reduction and output stages.
   localparam int unsigned DFLT_PIPE_LAT = 9 + 1 + 6 + 1;

endpackage

// File: rtl/iddmm_ctrl_dly.sv
// Write-back delay line: a DEPTH-stage shift register of WIDTH-bit entries.
// It shifts every cycle, and a synchronous clear empties every stage at once.
module iddmm_ctrl_dly #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   // Shift one stage per cycle; reset or clear drops every entry in flight.
   // NOTE: this array is reset on purpose -- each stage carries a valid bit, and a stale one would fire a spurious write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
      end else if (clr_i) begin
         for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= din_i;
         for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/iddmm_ctrl.sv
// Sequencer for one word-serial Montgomery multiplication. For each outer word
// i it issues N+1 inner steps, which are the N operand words plus a carry-out
// step. It then waits PIPE_LAT cycles so that the last result word is written
// before the next pass reads it back.
module iddmm_ctrl
   import iddmm_pkg::*;
#(
   parameter int unsigned K        = DFLT_K,
   parameter int unsigned N        = DFLT_N,
   parameter int unsigned ADDR_W   = $clog2(N),
   parameter int unsigned PIPE_LAT = DFLT_PIPE_LAT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              issue_vld,
   output logic [ADDR_W:0]   j_cnt,
   output logic [ADDR_W-1:0] i_cnt,
   output logic [ADDR_W-1:0] x_addr,
   output logic [ADDR_W-1:0] y_addr,
   output logic [ADDR_W-1:0] p_addr,
   output logic [ADDR_W-1:0] a_addr,
   output logic              word_zero,
   output logic              c_clr,
   output logic              res_we,
   output logic [ADDR_W-1:0] res_addr
);

   localparam int unsigned JW = ADDR_W + 1;
   localparam int unsigned DW = $clog2(PIPE_LAT + 1);

   localparam logic [JW-1:0]     J_LAST = JW'(N);
   localparam logic [ADDR_W-1:0] I_LAST = ADDR_W'(N - 1);
   localparam logic [DW-1:0]     D_LAST = DW'(PIPE_LAT - 1);

   // K sizes only the datapath; this control block does not depend on it.
   if (K == 0) begin : g_k_unused
   end

   state_e            state_q;
   logic [ADDR_W-1:0] i_cnt_q;
   logic [JW-1:0]     j_cnt_q;
   logic [DW-1:0]     d_cnt_q;

   logic              in_issue;
   logic              j_last;
   logic [ADDR_W-1:0] word_addr;
   logic [JW-1:0]     wb_d;
   logic [JW-1:0]     wb_q;

   // Sequencing FSM. Abort has priority over everything else, including start.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         i_cnt_q <= '0;
         j_cnt_q <= '0;
         d_cnt_q <= '0;
      end else if (abort) begin
         state_q <= S_IDLE;
         i_cnt_q <= '0;
         j_cnt_q <= '0;
         d_cnt_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_ISSUE;
                  i_cnt_q <= '0;
                  j_cnt_q <= '0;
               end
            end
            S_ISSUE: begin
               if (j_cnt_q == J_LAST) begin
                  state_q <= S_DRAIN;
                  d_cnt_q <= '0;
               end else begin
                  j_cnt_q <= j_cnt_q + JW'(1);
               end
            end
            S_DRAIN: begin
               if (d_cnt_q == D_LAST) begin
                  if (i_cnt_q == I_LAST) begin
                     state_q <= S_FIN;
                  end else begin
                     state_q <= S_ISSUE;
                     i_cnt_q <= i_cnt_q + ADDR_W'(1);
                     j_cnt_q <= '0;
                  end
               end else begin
                  d_cnt_q <= d_cnt_q + DW'(1);
               end
            end
            S_FIN: begin
               state_q <= S_IDLE;
               i_cnt_q <= '0;
               j_cnt_q <= '0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Outputs are decoded from registers only, so they stay glitch-free relative to the inputs.
   assign in_issue  = (state_q == S_ISSUE);
   assign j_last    = (j_cnt_q == J_LAST);
   assign word_addr = (in_issue && !j_last) ? j_cnt_q[ADDR_W-1:0] : '0;

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_FIN);
   assign issue_vld = in_issue;
   assign j_cnt     = j_cnt_q;
   assign i_cnt     = i_cnt_q;
   assign x_addr    = i_cnt_q;
   assign y_addr    = word_addr;
   assign p_addr    = word_addr;
   assign a_addr    = word_addr;
   assign word_zero = in_issue && j_last;
   assign c_clr     = in_issue && (j_cnt_q == '0);

   // Step j produces result word j-1; step 0 only primes the carry and writes nothing.
   assign wb_d = {in_issue && (j_cnt_q != '0), ADDR_W'(j_cnt_q - JW'(1))};

   iddmm_ctrl_dly #(
      .DEPTH (PIPE_LAT),
      .WIDTH (JW)
   ) u_dly (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (abort),
      .din_i  (wb_d),
      .dout_o (wb_q)
   );

   assign res_we   = wb_q[ADDR_W];
   assign res_addr = wb_q[ADDR_W-1:0];

endmodule
